// File: rtl/titan_bus_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// titan_bus_pkg: shared types and widths for the titan bus arbiter.  Rev 1.0
// ---------------------------------------------------------------------------
package titan_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic IMST = 1'b0;
    localparam logic DMST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/titan_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// titan_bus_arbiter_if: instruction/data master and shared slave bundle.  Rev 1.0
// ---------------------------------------------------------------------------
interface titan_bus_arbiter_if;
    import titan_bus_pkg::*;

    logic [ADDR_W-1:0] iaddr_i;
    logic              icyc_i;
    logic              istb_i;
    logic [DATA_W-1:0] idat_o;
    logic              iack_o;
    logic              ierr_o;

    logic [ADDR_W-1:0] daddr_i;
    logic [DATA_W-1:0] ddat_i;
    logic [SEL_W-1:0]  dsel_i;
    logic              dwe_i;
    logic              dcyc_i;
    logic              dstb_i;
    logic [DATA_W-1:0] ddat_o;
    logic              dack_o;
    logic              derr_o;

    logic [ADDR_W-1:0] xaddr_o;
    logic [DATA_W-1:0] xdat_o;
    logic [SEL_W-1:0]  xsel_o;
    logic              xwe_o;
    logic              xcyc_o;
    logic              xstb_o;
    logic [DATA_W-1:0] xdat_i;
    logic              xack_i;
    logic              xerr_i;

    // Arbiter side: it is the slave of both masters and drives the shared slave.
    modport slave (
        input  iaddr_i, icyc_i, istb_i,
        output idat_o, iack_o, ierr_o,
        input  daddr_i, ddat_i, dsel_i, dwe_i, dcyc_i, dstb_i,
        output ddat_o, dack_o, derr_o,
        output xaddr_o, xdat_o, xsel_o, xwe_o, xcyc_o, xstb_o,
        input  xdat_i, xack_i, xerr_i
    );

    modport master (
        output iaddr_i, icyc_i, istb_i,
        input  idat_o, iack_o, ierr_o,
        output daddr_i, ddat_i, dsel_i, dwe_i, dcyc_i, dstb_i,
        input  ddat_o, dack_o, derr_o,
        input  xaddr_o, xdat_o, xsel_o, xwe_o, xcyc_o, xstb_o,
        output xdat_i, xack_i, xerr_i
    );

endinterface
`default_nettype wire

// File: rtl/titan_bus_timeout.sv
`default_nettype none
// ---------------------------------------------------------------------------
// titan_bus_timeout: saturating wait counter flagging a stalled bus cycle.  Rev 1.0
// ---------------------------------------------------------------------------
module titan_bus_timeout #(
    parameter int TIMEOUT = 255
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic clr,
    input  wire logic cnt_en,
    output logic      expired
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Holds at LAST_CNT rather than wrapping if stb drops right at the limit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (cnt_en && (count != LAST_CNT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = cnt_en && (count == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/titan_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// titan_bus_arbiter: round-robin Wishbone arbiter, instruction + data masters.  Rev 1.0
// ---------------------------------------------------------------------------
module titan_bus_arbiter
    import titan_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    titan_bus_arbiter_if.slave bus
);

    logic   rst_meta;
    logic   rst_sync;
    state_t state;
    logic   last;
    logic   ireq;
    logic   dreq;
    logic   owner_cyc;
    logic   owner_stb;
    logic   cnt_en;
    logic   cnt_clr;
    logic   expired;

    // Assertion is immediate; release is retimed to clk_i.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign ireq      = bus.icyc_i & bus.istb_i;
    assign dreq      = bus.dcyc_i & bus.dstb_i;
    assign owner_cyc = (state == IGNT) ? bus.icyc_i : bus.dcyc_i;
    assign owner_stb = ((state == IGNT) & bus.istb_i) | ((state == DGNT) & bus.dstb_i);
    assign cnt_en    = owner_stb & ~bus.xack_i & ~bus.xerr_i;
    assign cnt_clr   = (state == IDLE) | bus.xack_i | bus.xerr_i;

    titan_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_sync),
        .clr     (cnt_clr),
        .cnt_en  (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge clk_i or negedge rst_sync) begin
        if (!rst_sync) begin
            state <= IDLE;
            last  <= IMST;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq && dreq) begin
                        if (last == IMST) begin
                            state <= DGNT;
                            last  <= DMST;
                        end else begin
                            state <= IGNT;
                            last  <= IMST;
                        end
                    end else if (dreq) begin
                        state <= DGNT;
                        last  <= DMST;
                    end else if (ireq) begin
                        state <= IGNT;
                        last  <= IMST;
                    end
                end
                IGNT, DGNT: begin
                    if (expired || !owner_cyc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.xaddr_o = '0;
        bus.xdat_o  = '0;
        bus.xsel_o  = '0;
        bus.xwe_o   = 1'b0;
        bus.xcyc_o  = 1'b0;
        bus.xstb_o  = 1'b0;
        bus.iack_o  = 1'b0;
        bus.ierr_o  = 1'b0;
        bus.dack_o  = 1'b0;
        bus.derr_o  = 1'b0;
        bus.idat_o  = bus.xdat_i;
        bus.ddat_o  = bus.xdat_i;
        case (state)
            IGNT: begin
                bus.xaddr_o = bus.iaddr_i;
                bus.xsel_o  = {SEL_W{1'b1}};
                bus.xcyc_o  = bus.icyc_i & ~expired;
                bus.xstb_o  = bus.istb_i & ~expired;
                bus.iack_o  = bus.xack_i;
                bus.ierr_o  = bus.xerr_i | expired;
            end
            DGNT: begin
                bus.xaddr_o = bus.daddr_i;
                bus.xdat_o  = bus.ddat_i;
                bus.xsel_o  = bus.dsel_i;
                bus.xwe_o   = bus.dwe_i;
                bus.xcyc_o  = bus.dcyc_i & ~expired;
                bus.xstb_o  = bus.dstb_i & ~expired;
                bus.dack_o  = bus.xack_i;
                bus.derr_o  = bus.xerr_i | expired;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_titan_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_titan_bus_arbiter: directed self-checking bench, TIMEOUT = 4.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_titan_bus_arbiter;

    localparam logic [31:0] IADDR = 32'h0000_1000;
    localparam logic [31:0] DADDR = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    titan_bus_arbiter_if bus ();

    titan_bus_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.iaddr_i = '0; bus.icyc_i = 1'b0; bus.istb_i = 1'b0;
        bus.daddr_i = '0; bus.ddat_i = '0; bus.dsel_i = '0;
        bus.dwe_i = 1'b0; bus.dcyc_i = 1'b0; bus.dstb_i = 1'b0;
        bus.xdat_i = '0; bus.xack_i = 1'b0; bus.xerr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.iaddr_i = 32'hFFFF_0000; bus.icyc_i = 1'b1; bus.istb_i = 1'b1; bus.xack_i = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++; if (bus.xcyc_o !== 1'b0) begin errors++; $display("FAIL reset_xcyc: got %b expected 0", bus.xcyc_o); end
        checks++; if (bus.xaddr_o !== 32'h0) begin errors++; $display("FAIL reset_xaddr: got %h expected 0", bus.xaddr_o); end
        checks++; if ({bus.iack_o, bus.ierr_o, bus.dack_o, bus.derr_o} !== 4'b0000) begin errors++; $display("FAIL reset_acks: got %b expected 0000", {bus.iack_o, bus.ierr_o, bus.dack_o, bus.derr_o}); end
        checks++; if ({bus.xstb_o, bus.xwe_o, bus.xsel_o} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 0", {bus.xstb_o, bus.xwe_o, bus.xsel_o}); end
        clear_inputs();
        step();
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_conflict();
        bus.iaddr_i = IADDR; bus.icyc_i = 1'b1; bus.istb_i = 1'b1;
        bus.daddr_i = DADDR; bus.dcyc_i = 1'b1; bus.dstb_i = 1'b1;
        step();
        bus.xack_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.xaddr_o !== DADDR) begin errors++; $display("FAIL conflict_first_data: got %h expected %h", bus.xaddr_o, DADDR); end
        checks++; if ({bus.dack_o, bus.iack_o} !== 2'b10) begin errors++; $display("FAIL conflict_dack_route: got %b expected 10", {bus.dack_o, bus.iack_o}); end
        step();
        bus.xack_i = 1'b0; bus.dcyc_i = 1'b0; bus.dstb_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.xcyc_o !== 1'b0) begin errors++; $display("FAIL conflict_drop_cyc: got %b expected 0", bus.xcyc_o); end
        step();
        @(negedge clk);
        checks++; if (bus.xcyc_o !== 1'b0) begin errors++; $display("FAIL conflict_idle_gap: got %b expected 0", bus.xcyc_o); end
        step();
        bus.xack_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.xaddr_o !== IADDR || bus.xcyc_o !== 1'b1) begin errors++; $display("FAIL conflict_then_instr: got %h/%b expected %h/1", bus.xaddr_o, bus.xcyc_o, IADDR); end
        checks++; if ({bus.dack_o, bus.iack_o} !== 2'b01) begin errors++; $display("FAIL conflict_iack_route: got %b expected 01", {bus.dack_o, bus.iack_o}); end
        step();
        clear_inputs();
        repeat (2) step();
    endtask

    task automatic test_ifetch();
        bus.iaddr_i = 32'h0000_0100; bus.icyc_i = 1'b1; bus.istb_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.xcyc_o !== 1'b0) begin errors++; $display("FAIL ifetch_latency: got %b expected 0", bus.xcyc_o); end
        step();
        @(negedge clk);
        checks++; if (bus.xcyc_o !== 1'b1 || bus.xstb_o !== 1'b1) begin errors++; $display("FAIL ifetch_cyc_stb: got %b%b expected 11", bus.xcyc_o, bus.xstb_o); end
        checks++; if (bus.xaddr_o !== 32'h0000_0100) begin errors++; $display("FAIL ifetch_addr: got %h expected 00000100", bus.xaddr_o); end
        checks++; if ({bus.xsel_o, bus.xwe_o} !== 5'b11110 || bus.xdat_o !== 32'h0) begin errors++; $display("FAIL ifetch_sel_we_dat: got %b %h expected 11110 0", {bus.xsel_o, bus.xwe_o}, bus.xdat_o); end
        step();
        step();
        bus.xack_i = 1'b1; bus.xdat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if ({bus.iack_o, bus.ierr_o, bus.dack_o} !== 3'b100) begin errors++; $display("FAIL ifetch_ack: got %b expected 100", {bus.iack_o, bus.ierr_o, bus.dack_o}); end
        checks++; if (bus.idat_o !== 32'hDEAD_BEEF || bus.ddat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ifetch_rdata: got %h/%h expected deadbeef", bus.idat_o, bus.ddat_o); end
        step();
        bus.xack_i = 1'b0; bus.icyc_i = 1'b0; bus.istb_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.iack_o !== 1'b0 || bus.xcyc_o !== 1'b0) begin errors++; $display("FAIL ifetch_ack_once: got %b%b expected 00", bus.iack_o, bus.xcyc_o); end
        step();
        @(negedge clk);
        checks++; if (bus.xaddr_o !== 32'h0) begin errors++; $display("FAIL ifetch_idle_addr: got %h expected 0", bus.xaddr_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_data_write();
        bus.daddr_i = 32'h0000_0010; bus.ddat_i = 32'h0000_00AA; bus.dsel_i = 4'h1;
        bus.dwe_i = 1'b1; bus.dcyc_i = 1'b1; bus.dstb_i = 1'b1;
        step();
        @(negedge clk);
        checks++; if ({bus.xwe_o, bus.xsel_o} !== 5'b10001) begin errors++; $display("FAIL write_we_sel: got %b expected 10001", {bus.xwe_o, bus.xsel_o}); end
        checks++; if (bus.xdat_o !== 32'h0000_00AA || bus.xaddr_o !== 32'h10) begin errors++; $display("FAIL write_dat_addr: got %h/%h expected 000000aa/00000010", bus.xdat_o, bus.xaddr_o); end
        bus.xack_i = 1'b1; bus.xerr_i = 1'b1;
        #1;
        checks++; if ({bus.dack_o, bus.derr_o, bus.iack_o, bus.ierr_o} !== 4'b1100) begin errors++; $display("FAIL write_ack_and_err: got %b expected 1100", {bus.dack_o, bus.derr_o, bus.iack_o, bus.ierr_o}); end
        step();
        clear_inputs();
        repeat (2) step();
    endtask

    task automatic test_timeout();
        bus.iaddr_i = IADDR; bus.icyc_i = 1'b1; bus.istb_i = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            @(negedge clk);
            checks++; if (bus.ierr_o !== (c == 4)) begin errors++; $display("FAIL timeout_err_cycle%0d: got %b expected %b", c, bus.ierr_o, (c == 4)); end
            checks++; if (bus.xcyc_o !== (c != 4) || bus.xstb_o !== (c != 4)) begin errors++; $display("FAIL timeout_cyc_cycle%0d: got %b%b expected %b", c, bus.xcyc_o, bus.xstb_o, (c != 4)); end
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++; if (bus.xcyc_o !== 1'b0 || bus.ierr_o !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b%b expected 00", bus.xcyc_o, bus.ierr_o); end
        step();
    endtask

    task automatic test_ack_wins();
        bus.iaddr_i = IADDR; bus.icyc_i = 1'b1; bus.istb_i = 1'b1;
        repeat (4) step();
        bus.xack_i = 1'b1;
        @(negedge clk);
        checks++; if ({bus.iack_o, bus.ierr_o, bus.xcyc_o} !== 3'b101) begin errors++; $display("FAIL ackwin_limit: got %b expected 101", {bus.iack_o, bus.ierr_o, bus.xcyc_o}); end
        step();
        bus.xack_i = 1'b0;
        @(negedge clk);
        checks++; if ({bus.ierr_o, bus.xcyc_o} !== 2'b01) begin errors++; $display("FAIL ackwin_counter_clr: got %b expected 01", {bus.ierr_o, bus.xcyc_o}); end
        step();
        clear_inputs();
        repeat (2) step();
    endtask

    task automatic test_reset_mid_grant();
        bus.daddr_i = DADDR; bus.dcyc_i = 1'b1; bus.dstb_i = 1'b1;
        step();
        @(negedge clk);
        checks++; if (bus.xcyc_o !== 1'b1) begin errors++; $display("FAIL midrst_granted: got %b expected 1", bus.xcyc_o); end
        step();
        bus.xack_i = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.xcyc_o !== 1'b0) begin errors++; $display("FAIL midrst_async_abort: got %b expected 0", bus.xcyc_o); end
        checks++; if (bus.dack_o !== 1'b0 || bus.derr_o !== 1'b0) begin errors++; $display("FAIL midrst_no_ack: got %b%b expected 00", bus.dack_o, bus.derr_o); end
        step();
        clear_inputs();
        rst_n = 1'b1;
        repeat (3) step();
        bus.iaddr_i = IADDR; bus.icyc_i = 1'b1; bus.istb_i = 1'b1;
        bus.daddr_i = DADDR; bus.dcyc_i = 1'b1; bus.dstb_i = 1'b1;
        step();
        bus.xack_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.xaddr_o !== DADDR) begin errors++; $display("FAIL midrst_first_conflict: got %h expected %h", bus.xaddr_o, DADDR); end
        step();
        clear_inputs();
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        logic exp_d;
        exp_d = 1'b0;
        bus.iaddr_i = IADDR; bus.icyc_i = 1'b1; bus.istb_i = 1'b1;
        bus.daddr_i = DADDR; bus.dcyc_i = 1'b1; bus.dstb_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            bus.xack_i = 1'b1;
            @(negedge clk);
            checks++; if (bus.xaddr_o !== (exp_d ? DADDR : IADDR)) begin errors++; $display("FAIL b2b_owner%0d: got %h expected %h", k, bus.xaddr_o, (exp_d ? DADDR : IADDR)); end
            checks++; if ({bus.dack_o, bus.iack_o} !== (exp_d ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_ack%0d: got %b expected %b", k, {bus.dack_o, bus.iack_o}, (exp_d ? 2'b10 : 2'b01)); end
            step();
            bus.xack_i = 1'b0;
            if (exp_d) begin bus.dcyc_i = 1'b0; bus.dstb_i = 1'b0; end
            else       begin bus.icyc_i = 1'b0; bus.istb_i = 1'b0; end
            step();
            if (exp_d) begin bus.dcyc_i = 1'b1; bus.dstb_i = 1'b1; end
            else       begin bus.icyc_i = 1'b1; bus.istb_i = 1'b1; end
            exp_d = ~exp_d;
        end
        clear_inputs();
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_ifetch();
        test_data_write();
        test_timeout();
        test_ack_wins();
        test_reset_mid_grant();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
